// File: rtl/hazard_scoreboard.sv
// Register-dependency scoreboard that sits beside the ID stage.
// Each architectural register r != 0 has a small counter of in-flight writes.
// The counter goes up when ID issues a write and down when WB retires one.
// freeze stalls ID/IF while a source operand still has an outstanding producer.
// Build option HAZARD_PERF_EN adds a saturating 16-bit stall counter
// (stall_count) and a synchronous clear input (perf_clr).
module hazard_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        src1,
  input  logic [ADDR_W-1:0]        src2,
  input  logic                     src2_check,
  input  logic                     id_wb_en,
  input  logic [ADDR_W-1:0]        id_dest,
  input  logic                     flush,
  input  logic                     wb_write_en,
  input  logic [ADDR_W-1:0]        wb_dest,
  output logic                     freeze,
  output logic                     busy,
  output logic [(1<<ADDR_W)-1:0]   pending_mask
`ifdef HAZARD_PERF_EN
  ,
  input  logic                     perf_clr,
  output logic [15:0]              stall_count
`endif
);

  localparam int NREG = 1 << ADDR_W;

  // Entry 0 exists only so the array can be indexed directly; it is never written.
  logic [CNT_W-1:0] cnt     [NREG];
  logic [CNT_W-1:0] cnt_nxt [NREG];
  logic [NREG-1:0]  pend_nxt;

  logic hazard1;
  logic hazard2;
  logic sat;
  logic issue;
  logic retire;

  // Hazard and issue decisions come from the registered counts only. A writeback
  // in this cycle therefore releases freeze starting in the next cycle.
  assign hazard1 = (src1 != '0) && (cnt[src1] != '0);
  assign hazard2 = src2_check && (src2 != '0) && (cnt[src2] != '0);
  assign sat     = id_wb_en && (id_dest != '0) && (&cnt[id_dest]);
  assign freeze  = (hazard1 || hazard2 || sat) && !flush;
  assign issue   = id_wb_en && (id_dest != '0) && !freeze && !flush;
  assign retire  = wb_write_en && (wb_dest != '0);

  // Compute the next counters. An issue and a retire to the same register cancel out.
  // A retire to a register whose count is already zero leaves it at zero.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      cnt_nxt[i]  = cnt[i];
      pend_nxt[i] = 1'b0;
      if (i != 0) begin
        if (issue && (id_dest == ADDR_W'(i)) &&
            !(retire && (wb_dest == ADDR_W'(i))))
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        else if (retire && (wb_dest == ADDR_W'(i)) &&
                 !(issue && (id_dest == ADDR_W'(i))) && (cnt[i] != '0))
          cnt_nxt[i] = cnt[i] - CNT_W'(1);
        pend_nxt[i] = (cnt_nxt[i] != '0);
      end
    end
  end

  // Counter state, plus busy and pending_mask registered from the next-state counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
      busy         <= 1'b0;
      pending_mask <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) cnt[i] <= cnt_nxt[i];
      busy         <= |pend_nxt;
      pending_mask <= pend_nxt;
    end
  end

`ifdef HAZARD_PERF_EN
  // Frozen-cycle counter. It saturates at all-ones, and a clear wins over an increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_count <= '0;
    else if (perf_clr)
      stall_count <= '0;
    else if (freeze && (stall_count != 16'hFFFF))
      stall_count <= stall_count + 16'd1;
  end
`endif

`ifndef SYNTHESIS
  // Reports a writeback that has no matching issue still in flight.
  always @(posedge clk) begin
    if (!rst && retire && (cnt[wb_dest] == '0) && !(issue && (id_dest == wb_dest)))
      $display("hazard_scoreboard: retire to r%0d with no write in flight (t=%0t)",
               wb_dest, $time);
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard.
// Expected values are pushed to a queue when stimulus is driven and popped when the DUT output is sampled.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  src1, src2, id_dest, wb_dest;
  logic        src2_check, id_wb_en, flush, wb_write_en;
  logic        freeze, busy;
  logic [31:0] pending_mask;
  logic        perf_clr = 1'b0;
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int mc [32];
  int sc_model = 0;
  logic [63:0] exp_q [$];

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .src2_check(src2_check),
    .id_wb_en(id_wb_en), .id_dest(id_dest), .flush(flush),
    .wb_write_en(wb_write_en), .wb_dest(wb_dest),
    .freeze(freeze), .busy(busy), .pending_mask(pending_mask)
`ifdef HAZARD_PERF_EN
    , .perf_clr(perf_clr), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    for (int i = 1; i < 32; i++) m[i] = (mc[i] != 0);
    return m;
  endfunction

  function automatic logic model_freeze();
    logic h1, h2, st;
    h1 = (src1 != 0) && (mc[src1] != 0);
    h2 = src2_check && (src2 != 0) && (mc[src2] != 0);
    st = id_wb_en && (id_dest != 0) && (mc[id_dest] == 3);
    return (h1 || h2 || st) && !flush;
  endfunction

  // One clock cycle: drive inputs, check freeze, then check the registered outputs after the edge.
  task automatic step(input string tag, input logic [4:0] s1, input logic [4:0] s2,
                      input logic s2c, input logic wbe, input logic [4:0] idd,
                      input logic fl, input logic wwe, input logic [4:0] wd);
    logic ef, iss, ret;
    @(negedge clk);
    src1 = s1; src2 = s2; src2_check = s2c; id_wb_en = wbe; id_dest = idd;
    flush = fl; wb_write_en = wwe; wb_dest = wd;
    #1;
    ef = model_freeze();
    exp_q.push_back(64'(ef));
    chk({tag, ".freeze"}, 64'(freeze), exp_q.pop_front());
    iss = wbe && (idd != 0) && !ef && !fl;
    ret = wwe && (wd != 0);
    if (!(iss && ret && idd == wd)) begin
      if (iss) mc[idd]++;
      if (ret && mc[wd] > 0) mc[wd]--;
    end
    if (perf_clr) sc_model = 0;
    else if (ef && sc_model != 16'hFFFF) sc_model++;
    exp_q.push_back(64'(model_mask()));
    exp_q.push_back(64'(model_mask() != 0));
    @(posedge clk);
    #1;
    chk({tag, ".mask"}, 64'(pending_mask), exp_q.pop_front());
    chk({tag, ".busy"}, 64'(busy), exp_q.pop_front());
  endtask

  task automatic idle(input string tag, input logic [4:0] s1);
    step(tag, s1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
  endtask
  task automatic iss(input string tag, input logic [4:0] d);
    step(tag, 5'd0, 5'd0, 1'b0, 1'b1, d, 1'b0, 1'b0, 5'd0);
  endtask
  task automatic ret(input string tag, input logic [4:0] d);
    step(tag, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, d);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mc[i] = 0;
    rst = 1'b1;
    src1 = 0; src2 = 0; src2_check = 0; id_wb_en = 0; id_dest = 0;
    flush = 0; wb_write_en = 0; wb_dest = 0;
    #2;
    chk("reset.freeze", 64'(freeze), 64'd0);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.mask", 64'(pending_mask), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a stall.
    iss("rst_pre", 5'd3);
    @(negedge clk);
    src1 = 5'd3; id_wb_en = 0; wb_write_en = 0;
    #1;
    chk("rst_pre.freeze", 64'(freeze), 64'd1);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) mc[i] = 0;
    sc_model = 0;
    chk("rst_mid.freeze", 64'(freeze), 64'd0);
    chk("rst_mid.busy", 64'(busy), 64'd0);
    chk("rst_mid.mask", 64'(pending_mask), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle("rst_post", 5'd3);

    // RAW on src1: freeze holds through the retire cycle and drops one cycle later.
    iss("raw_issue", 5'd5);
    for (int k = 0; k < 3; k++) idle("raw_wait", 5'd5);
    step("raw_retire", 5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5);
    idle("raw_release", 5'd5);

    // src2_check gating, and writes to r0 never create a hazard.
    iss("s2_issue", 5'd7);
    step("s2_nochk", 5'd0, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    step("s2_chk", 5'd0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    ret("s2_retire", 5'd7);
    iss("r0_issue", 5'd0);
    idle("r0_src", 5'd0);

    // WAW: two issues, an issue and retire together, then two retires.
    iss("waw_i1", 5'd9);
    iss("waw_i2", 5'd9);
    step("waw_both", 5'd0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 5'd9);
    ret("waw_r1", 5'd9);
    ret("waw_r2", 5'd9);

    // Issue and retire to different registers in the same cycle.
    iss("mix_pre", 5'd10);
    step("mix", 5'd0, 5'd0, 1'b0, 1'b1, 5'd11, 1'b0, 1'b1, 5'd10);
    ret("mix_post", 5'd11);

    // A retire with no write in flight leaves the count at zero.
    ret("underflow", 5'd12);
    idle("underflow_src", 5'd12);

    // Saturation stall, and a flush in the same cycle.
    for (int k = 0; k < 3; k++) iss("sat_fill", 5'd4);
    iss("sat_stall", 5'd4);
    step("sat_flush", 5'd0, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 5'd0);
    ret("sat_r1", 5'd4);
    ret("sat_r2", 5'd4);
    ret("sat_r3", 5'd4);

`ifdef HAZARD_PERF_EN
    perf_clr = 1'b1;
    idle("perf_clr0", 5'd0);
    perf_clr = 1'b0;
    iss("perf_issue", 5'd1);
    for (int k = 0; k < 6; k++) idle("perf_stall", 5'd1);
    chk("perf.six", 64'(stall_count), 64'(sc_model));
    chk("perf.six_const", 64'(stall_count), 64'd6);
    perf_clr = 1'b1;
    idle("perf_clr_frozen", 5'd1);
    perf_clr = 1'b0;
    chk("perf.clr", 64'(stall_count), 64'd0);
    for (int k = 0; k < 65534; k++) @(posedge clk);
    sc_model = 65534;
    #1;
    chk("perf.fffe", 64'(stall_count), 64'hFFFE);
    for (int k = 0; k < 3; k++) idle("perf_sat", 5'd1);
    chk("perf.sat", 64'(stall_count), 64'hFFFF);
    ret("perf_retire", 5'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
